br_rs_sched: RTL



---
 rtl/br_rs_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/br_rs_sched.sv
// ============================================================================
// Module   : br_rs_sched
// Purpose  : Branch reservation station and issue scheduler for a single shared
//            branch comparator. Holds up to DEPTH dispatched branches in an
//            age-ordered compacting queue (index 0 = oldest), captures operands
//            from CDB broadcasts, issues the oldest fully-ready branch to the
//            comparator each cycle and buffers the taken/not-taken result until
//            the consumer accepts it.
// Ports    : clk, rst_n (async, active low), flush (sync)
//            alloc_*  : dispatch interface (valid/ready, funct3, tag, operands)
//            cdb_*    : common data bus wakeup broadcast
//            cmp_*    : comparator drive (op, operands) and result cmp_br_en
//            res_*    : buffered branch outcome with valid/ready handshake
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_rs_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [2:0]       alloc_funct3,
    input  logic [TAG_W-1:0] alloc_rob_tag,
    input  logic             alloc_a_rdy,
    input  logic             alloc_b_rdy,
    input  logic [31:0]      alloc_a_val,
    input  logic [31:0]      alloc_b_val,
    input  logic [TAG_W-1:0] alloc_a_tag,
    input  logic [TAG_W-1:0] alloc_b_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic [2:0]       cmp_op,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_br_en,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_rob_tag,
    output logic             res_taken,
    input  logic             res_ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [2:0]       f3;
        logic [TAG_W-1:0] rob_tag;
        logic             a_rdy;
        logic [TAG_W-1:0] a_tag;
        logic [31:0]      a_val;
        logic             b_rdy;
        logic [TAG_W-1:0] b_tag;
        logic [31:0]      b_val;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woke  [DEPTH];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q, count_d, cnt_after;
    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_taken_q, res_taken_d;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    logic             do_alloc;

    // Capacity is judged on registered occupancy only; an issue in the same
    // cycle does not free a slot for dispatch until the next cycle.
    assign alloc_ready = (count_q < CNT_W'(DEPTH));
    assign do_alloc    = alloc_valid && alloc_ready;

    // Oldest valid entry with both operands ready (reverse scan keeps lowest).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count_q) && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign cmp_op = sel_found ? ent_q[sel_idx].f3    : 3'd0;
    assign cmp_a  = sel_found ? ent_q[sel_idx].a_val : 32'd0;
    assign cmp_b  = sel_found ? ent_q[sel_idx].b_val : 32'd0;

    assign issue  = sel_found && (!res_valid_q || res_ready);

    // Incoming entry, with same-cycle CDB bypass for operands still pending.
    always_comb begin
        new_ent         = '0;
        new_ent.f3      = alloc_funct3;
        new_ent.rob_tag = alloc_rob_tag;
        new_ent.a_tag   = alloc_a_tag;
        new_ent.b_tag   = alloc_b_tag;
        new_ent.a_rdy   = alloc_a_rdy || (cdb_valid && (alloc_a_tag == cdb_tag));
        new_ent.a_val   = alloc_a_rdy ? alloc_a_val : cdb_data;
        new_ent.b_rdy   = alloc_b_rdy || (cdb_valid && (alloc_b_tag == cdb_tag));
        new_ent.b_val   = alloc_b_rdy ? alloc_b_val : cdb_data;
    end

    // Wakeup is applied before the shift so captured values travel with
    // their entry when it moves down a slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid && !ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
                woke[i].a_rdy = 1'b1;
                woke[i].a_val = cdb_data;
            end
            if (cdb_valid && !ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_tag)) begin
                woke[i].b_rdy = 1'b1;
                woke[i].b_val = cdb_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woke[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && (i >= int'(sel_idx))) begin
                ent_d[i] = woke[i + 1];
            end
        end
        cnt_after = issue ? (count_q - CNT_W'(1)) : count_q;
        if (do_alloc) begin
            ent_d[cnt_after[IDX_W-1:0]] = new_ent;
        end
        count_d = cnt_after + CNT_W'(do_alloc);
        if (flush) begin
            count_d = '0;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_taken_d = res_taken_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (issue) begin
            res_valid_d = 1'b1;
            res_tag_d   = ent_q[sel_idx].rob_tag;
            res_taken_d = cmp_br_en;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_taken_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_taken_q <= res_taken_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign res_valid   = res_valid_q;
    assign res_rob_tag = res_tag_q;
    assign res_taken   = res_taken_q;

endmodule

`default_nettype wire
